// File: rtl/dcache_stb_writer_if.sv
// Bundles the store-buffer, data-memory, flush, probe and counter signals
// of the data-cache write controller. The controller uses the slave view.
// Handshakes: stb2dcache_req is held with its payload until dcache2stb_ack
// pulses; dcache2mem_req and its payload stay stable until mem2dcache_ack
// is sampled high on a rising edge.
interface dcache_stb_writer_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
    logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
    logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
    logic                      stb2dcache_w_en;
    logic                      stb2dcache_req;
    logic                      dmem_sel_i;
    logic                      dcache2stb_ack;
    logic [ADDR_WIDTH-1:0]     dcache2mem_addr;
    logic [DATA_WIDTH-1:0]     dcache2mem_wdata;
    logic [BYTE_SEL_WIDTH-1:0] dcache2mem_sel_byte;
    logic                      dcache2mem_req;
    logic                      mem2dcache_ack;
    logic                      dcache_flush;
    logic                      dcache_flush_busy;
    logic [ADDR_WIDTH-1:0]     lsummu2dcache_raddr;
    logic [DATA_WIDTH-1:0]     dcache2lsummu_rdata;
    logic                      dcache2lsummu_rhit;
    logic [15:0]               wr_hit_cnt;
    logic [15:0]               wr_miss_cnt;
    logic [2:0]                dbg_state;

    modport slave (
        input  stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte,
        input  stb2dcache_w_en, stb2dcache_req, dmem_sel_i,
        output dcache2stb_ack,
        output dcache2mem_addr, dcache2mem_wdata, dcache2mem_sel_byte, dcache2mem_req,
        input  mem2dcache_ack,
        input  dcache_flush,
        output dcache_flush_busy,
        input  lsummu2dcache_raddr,
        output dcache2lsummu_rdata, dcache2lsummu_rhit,
        output wr_hit_cnt, wr_miss_cnt,
        output dbg_state
    );

    modport master (
        output stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte,
        output stb2dcache_w_en, stb2dcache_req, dmem_sel_i,
        input  dcache2stb_ack,
        input  dcache2mem_addr, dcache2mem_wdata, dcache2mem_sel_byte, dcache2mem_req,
        output mem2dcache_ack,
        output dcache_flush,
        input  dcache_flush_busy,
        output lsummu2dcache_raddr,
        input  dcache2lsummu_rdata, dcache2lsummu_rhit,
        input  wr_hit_cnt, wr_miss_cnt,
        input  dbg_state
    );
endinterface

// File: rtl/dcache_stb_writer.sv
// Write-side data-cache controller: drains one store-buffer entry at a time,
// merges it into a direct-mapped write-through cache and forwards it to
// memory, acknowledging the store buffer only after memory accepted it.
module dcache_stb_writer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int NUM_LINES      = 16
) (
    input logic               clk,
    input logic               rst,
    dcache_stb_writer_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - 2;
    localparam int WADR_W = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_WR = 3'd2,
        S_ACK    = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [WADR_W-1:0]         waddr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [BYTE_SEL_WIDTH-1:0] sel_q;
    logic                      wen_q;
    logic [NUM_LINES-1:0]      valid_q;
    logic [TAG_W-1:0]          tag_arr_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0]     data_arr_q [NUM_LINES];
    logic [IDX_W-1:0]          flush_cnt_q;
    logic [15:0]               hit_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0]          idx;
    logic [TAG_W-1:0]          tag;
    logic                      hit, do_update, write_line, accept;
    logic [DATA_WIDTH-1:0]     merged;
    logic [IDX_W-1:0]          ridx;
    logic [TAG_W-1:0]          rtag;
    logic                      unused_addr_bits;

    // Byte offset bits carry no information for a word-per-line cache.
    assign unused_addr_bits = ^{bus.stb2dcache_addr[1:0], bus.lsummu2dcache_raddr[1:0]};

    assign idx        = waddr_q[IDX_W-1:0];
    assign tag        = waddr_q[WADR_W-1:IDX_W];
    assign hit        = valid_q[idx] && (tag_arr_q[idx] == tag);
    assign do_update  = (state_q == S_LOOKUP) && wen_q;
    // Partial-word misses are not allocated: the rest of the line is unknown.
    assign write_line = do_update && (hit || (&sel_q));
    assign accept     = bus.stb2dcache_req && bus.dmem_sel_i;

    // Byte merge of the held store into the currently indexed line.
    always_comb begin
        merged = data_arr_q[idx];
        for (int i = 0; i < BYTE_SEL_WIDTH; i++) begin
            if (sel_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Next-state logic; flush wins over a simultaneous store request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dcache_flush) state_d = S_FLUSH;
                else if (accept)      state_d = S_LOOKUP;
            end
            S_LOOKUP: state_d = wen_q ? S_MEM_WR : S_ACK;
            S_MEM_WR: if (bus.mem2dcache_ack) state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            S_FLUSH:  if (flush_cnt_q == IDX_W'(NUM_LINES - 1)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Holding registers capture the store when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            wen_q   <= 1'b0;
        end else if (state_q == S_IDLE && !bus.dcache_flush && accept) begin
            waddr_q <= bus.stb2dcache_addr[ADDR_WIDTH-1:2];
            wdata_q <= bus.stb2dcache_wdata;
            sel_q   <= bus.stb2dcache_sel_byte;
            wen_q   <= bus.stb2dcache_w_en;
        end
    end

    // Valid bits: cleared by reset or the flush walk, set on allocate/hit write.
    always_ff @(posedge clk) begin
        if (rst)                       valid_q <= '0;
        else if (state_q == S_FLUSH)   valid_q[flush_cnt_q] <= 1'b0;
        else if (write_line)           valid_q[idx] <= 1'b1;
    end

    // Tag and data arrays are not reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (write_line) begin
            tag_arr_q[idx]  <= tag;
            data_arr_q[idx] <= merged;
        end
    end

    // Flush walk counter; wraps back to 0 after the last line.
    always_ff @(posedge clk) begin
        if (rst)                     flush_cnt_q <= '0;
        else if (state_q == S_FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
    end

    // Saturating hit/miss counters for write stores only.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (do_update) begin
            if (hit && hit_cnt_q != 16'hFFFF)        hit_cnt_q  <= hit_cnt_q + 16'd1;
            else if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign bus.dcache2stb_ack      = (state_q == S_ACK);
    assign bus.dcache_flush_busy   = (state_q == S_FLUSH);
    assign bus.dcache2mem_req      = (state_q == S_MEM_WR);
    assign bus.dcache2mem_addr     = bus.dcache2mem_req ? {waddr_q, 2'b00} : '0;
    assign bus.dcache2mem_wdata    = bus.dcache2mem_req ? wdata_q : '0;
    assign bus.dcache2mem_sel_byte = bus.dcache2mem_req ? sel_q : '0;
    assign bus.wr_hit_cnt          = hit_cnt_q;
    assign bus.wr_miss_cnt         = miss_cnt_q;
    assign bus.dbg_state           = state_q;

    assign ridx                    = bus.lsummu2dcache_raddr[IDX_W+1:2];
    assign rtag                    = bus.lsummu2dcache_raddr[ADDR_WIDTH-1:IDX_W+2];
    assign bus.dcache2lsummu_rdata = data_arr_q[ridx];
    assign bus.dcache2lsummu_rhit  = valid_q[ridx] && (tag_arr_q[ridx] == rtag);
endmodule

// File: tb/tb_dcache_stb_writer.sv
// Directed bench for dcache_stb_writer: inputs change on the falling edge,
// outputs are observed on the falling edge.
module tb_dcache_stb_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    dcache_stb_writer_if bus ();

    dcache_stb_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational probe read.
    task automatic probe(input logic [31:0] a, output logic h, output logic [31:0] d);
        bus.lsummu2dcache_raddr = a;
        #1;
        h = bus.dcache2lsummu_rhit;
        d = bus.dcache2lsummu_rdata;
    endtask

    // Issues one store at a falling edge and plays the memory side with
    // 'waits' stall cycles. Reports cycle of ack (1 = first falling edge after
    // the request was sampled), memory request count, payload stability and
    // state of ack/req one cycle after the ack.
    task automatic run_store(
        input  logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
        input  logic w, input int waits, input bit flush_pulse,
        output int ack_cyc, output int req_cyc, output int busy_cyc, output bit stable,
        output logic [31:0] m_a, output logic [31:0] m_d, output logic [3:0] m_s,
        output logic ack_after, output logic req_after);
        ack_cyc = -1; req_cyc = 0; busy_cyc = 0; stable = 1'b1;
        m_a = '0; m_d = '0; m_s = '0;
        bus.stb2dcache_addr     = a;
        bus.stb2dcache_wdata    = d;
        bus.stb2dcache_sel_byte = s;
        bus.stb2dcache_w_en     = w;
        bus.stb2dcache_req      = 1'b1;
        if (flush_pulse) bus.dcache_flush = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) bus.dcache_flush = 1'b0;
            if (bus.dcache_flush_busy) busy_cyc++;
            if (bus.dcache2mem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    m_a = bus.dcache2mem_addr; m_d = bus.dcache2mem_wdata; m_s = bus.dcache2mem_sel_byte;
                end else if (m_a !== bus.dcache2mem_addr || m_d !== bus.dcache2mem_wdata ||
                             m_s !== bus.dcache2mem_sel_byte) begin
                    stable = 1'b0;
                end
                bus.mem2dcache_ack = (req_cyc == waits + 1);
            end else begin
                bus.mem2dcache_ack = 1'b0;
            end
            if (bus.dcache2stb_ack) begin
                ack_cyc = k;
                bus.stb2dcache_req = 1'b0;
                bus.mem2dcache_ack = 1'b0;
                break;
            end
        end
        bus.stb2dcache_req = 1'b0;
        @(negedge clk);
        ack_after = bus.dcache2stb_ack;
        req_after = bus.dcache2mem_req;
    endtask

    task automatic test_reset();
        logic h; logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.dcache2stb_ack, bus.dcache2mem_req, bus.dcache_flush_busy} !== 3'b000) begin
            $display("FAIL reset_ctrl: got %b expected 000", {bus.dcache2stb_ack, bus.dcache2mem_req, bus.dcache_flush_busy});
            n_fail++;
        end
        n_checks++;
        if (bus.dcache2mem_addr !== 32'h0 || bus.dcache2mem_wdata !== 32'h0 || bus.dcache2mem_sel_byte !== 4'h0) begin
            $display("FAIL reset_mem_bus: got %h %h %h expected zeros", bus.dcache2mem_addr, bus.dcache2mem_wdata, bus.dcache2mem_sel_byte);
            n_fail++;
        end
        n_checks++;
        if (bus.wr_hit_cnt !== 16'd0 || bus.wr_miss_cnt !== 16'd0) begin
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.wr_hit_cnt, bus.wr_miss_cnt);
            n_fail++;
        end
        probe(32'h1000, h, d);
        n_checks++;
        if (h !== 1'b0) begin
            $display("FAIL reset_probe: got rhit %b expected 0", h);
            n_fail++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_miss_allocate();
        int ac, rc, bc; bit st; logic [31:0] ma, md; logic [3:0] ms; logic aa, ra, h; logic [31:0] d;
        run_store(32'h1000, 32'hAAAA_BBBB, 4'b1111, 1'b1, 0, 1'b0, ac, rc, bc, st, ma, md, ms, aa, ra);
        n_checks++;
        if (ac != 3) begin $display("FAIL alloc_latency: got %0d expected 3", ac); n_fail++; end
        n_checks++;
        if (ma !== 32'h1000 || md !== 32'hAAAA_BBBB || ms !== 4'b1111 || rc != 1) begin
            $display("FAIL alloc_mem: got %h %h %b x%0d expected 00001000 aaaabbbb 1111 x1", ma, md, ms, rc);
            n_fail++;
        end
        n_checks++;
        if (aa !== 1'b0 || ra !== 1'b0) begin $display("FAIL alloc_ack_pulse: got ack %b req %b expected 0 0", aa, ra); n_fail++; end
        n_checks++;
        if (bus.wr_miss_cnt !== 16'd1) begin $display("FAIL alloc_miss_cnt: got %0d expected 1", bus.wr_miss_cnt); n_fail++; end
        probe(32'h1000, h, d);
        n_checks++;
        if (h !== 1'b1 || d !== 32'hAAAA_BBBB) begin $display("FAIL alloc_probe: got %b %h expected 1 aaaabbbb", h, d); n_fail++; end
    endtask

    task automatic test_hit_merge();
        int ac, rc, bc; bit st; logic [31:0] ma, md; logic [3:0] ms; logic aa, ra, h; logic [31:0] d;
        run_store(32'h1000, 32'h1234_5678, 4'b0101, 1'b1, 0, 1'b0, ac, rc, bc, st, ma, md, ms, aa, ra);
        probe(32'h1000, h, d);
        n_checks++;
        if (h !== 1'b1 || d !== 32'hAA34_BB78) begin $display("FAIL merge_probe: got %b %h expected 1 aa34bb78", h, d); n_fail++; end
        n_checks++;
        if (bus.wr_hit_cnt !== 16'd1 || bus.wr_miss_cnt !== 16'd1) begin
            $display("FAIL merge_cnt: got %0d/%0d expected 1/1", bus.wr_hit_cnt, bus.wr_miss_cnt); n_fail++;
        end
        n_checks++;
        if (ms !== 4'b0101 || md !== 32'h1234_5678 || ac != 3) begin
            $display("FAIL merge_mem: got sel %b data %h ack %0d expected 0101 12345678 3", ms, md, ac); n_fail++;
        end
    endtask

    task automatic test_partial_miss_alias();
        int ac, rc, bc; bit st; logic [31:0] ma, md; logic [3:0] ms; logic aa, ra, h; logic [31:0] d;
        run_store(32'h2004, 32'hFFFF_DDDD, 4'b0011, 1'b1, 0, 1'b0, ac, rc, bc, st, ma, md, ms, aa, ra);
        probe(32'h2004, h, d);
        n_checks++;
        if (h !== 1'b0 || bus.wr_miss_cnt !== 16'd2 || rc != 1) begin
            $display("FAIL partial_miss: got rhit %b miss %0d reqs %0d expected 0 2 1", h, bus.wr_miss_cnt, rc); n_fail++;
        end
        run_store(32'h1040, 32'hCCCC_DDDD, 4'b1111, 1'b1, 0, 1'b0, ac, rc, bc, st, ma, md, ms, aa, ra);
        probe(32'h1040, h, d);
        n_checks++;
        if (h !== 1'b1 || d !== 32'hCCCC_DDDD) begin $display("FAIL alias_new: got %b %h expected 1 ccccdddd", h, d); n_fail++; end
        probe(32'h1000, h, d);
        n_checks++;
        if (h !== 1'b0 || bus.wr_miss_cnt !== 16'd3) begin
            $display("FAIL alias_old: got rhit %b miss %0d expected 0 3", h, bus.wr_miss_cnt); n_fail++;
        end
    endtask

    task automatic test_backpressure();
        int ac, rc, bc; bit st; logic [31:0] ma, md; logic [3:0] ms; logic aa, ra, h; logic [31:0] d;
        run_store(32'h1043, 32'h0BAD_F00D, 4'b1111, 1'b1, 5, 1'b0, ac, rc, bc, st, ma, md, ms, aa, ra);
        n_checks++;
        if (ac != 8) begin $display("FAIL bp_latency: got %0d expected 8", ac); n_fail++; end
        n_checks++;
        if (rc != 6 || st !== 1'b1 || ra !== 1'b0) begin
            $display("FAIL bp_req: got %0d cycles stable %b req_after %b expected 6 1 0", rc, st, ra); n_fail++;
        end
        n_checks++;
        if (ma !== 32'h1040 || md !== 32'h0BAD_F00D) begin $display("FAIL bp_addr: got %h %h expected 00001040 0badf00d", ma, md); n_fail++; end
        probe(32'h1040, h, d);
        n_checks++;
        if (h !== 1'b1 || d !== 32'h0BAD_F00D || bus.wr_hit_cnt !== 16'd2) begin
            $display("FAIL bp_probe: got %b %h hit %0d expected 1 0badf00d 2", h, d, bus.wr_hit_cnt); n_fail++;
        end
    endtask

    task automatic test_read_only();
        int ac, rc, bc; bit st; logic [31:0] ma, md; logic [3:0] ms; logic aa, ra, h; logic [31:0] d;
        run_store(32'h1040, 32'hFFFF_FFFF, 4'b1111, 1'b0, 0, 1'b0, ac, rc, bc, st, ma, md, ms, aa, ra);
        n_checks++;
        if (ac != 2 || rc != 0) begin $display("FAIL rd_only: got ack %0d reqs %0d expected 2 0", ac, rc); n_fail++; end
        probe(32'h1040, h, d);
        n_checks++;
        if (d !== 32'h0BAD_F00D || bus.wr_hit_cnt !== 16'd2 || bus.wr_miss_cnt !== 16'd3) begin
            $display("FAIL rd_only_state: got %h %0d/%0d expected 0badf00d 2/3", d, bus.wr_hit_cnt, bus.wr_miss_cnt); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int acks[2]; int n_ack; int n_req; logic h; logic [31:0] d;
        n_ack = 0; n_req = 0; acks[0] = -1; acks[1] = -1;
        bus.stb2dcache_addr = 32'h1044; bus.stb2dcache_wdata = 32'h1111_1111;
        bus.stb2dcache_sel_byte = 4'b1111; bus.stb2dcache_w_en = 1'b1; bus.stb2dcache_req = 1'b1;
        for (int k = 1; k <= 30 && n_ack < 2; k++) begin
            @(negedge clk);
            if (bus.dcache2mem_req) n_req++;
            bus.mem2dcache_ack = bus.dcache2mem_req;
            if (bus.dcache2stb_ack) begin
                acks[n_ack] = k;
                n_ack++;
                bus.stb2dcache_addr = 32'h1048; bus.stb2dcache_wdata = 32'h2222_2222;
                if (n_ack == 2) bus.stb2dcache_req = 1'b0;
            end
        end
        bus.stb2dcache_req = 1'b0; bus.mem2dcache_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (acks[0] != 3 || acks[1] != 7 || n_req != 2) begin
            $display("FAIL b2b_timing: got acks %0d,%0d reqs %0d expected 3,7 2", acks[0], acks[1], n_req); n_fail++;
        end
        probe(32'h1048, h, d);
        n_checks++;
        if (h !== 1'b1 || d !== 32'h2222_2222 || bus.wr_miss_cnt !== 16'd5) begin
            $display("FAIL b2b_state: got %b %h miss %0d expected 1 22222222 5", h, d, bus.wr_miss_cnt); n_fail++;
        end
    endtask

    task automatic test_flush_race();
        int ac, rc, bc; bit st; logic [31:0] ma, md; logic [3:0] ms; logic aa, ra, h, h0, h1, h2; logic [31:0] d;
        run_store(32'h3008, 32'h3333_3333, 4'b1111, 1'b1, 0, 1'b1, ac, rc, bc, st, ma, md, ms, aa, ra);
        n_checks++;
        if (bc != 16 || ac != 20 || rc != 1) begin
            $display("FAIL flush_timing: got busy %0d ack %0d reqs %0d expected 16 20 1", bc, ac, rc); n_fail++;
        end
        probe(32'h1040, h0, d);
        probe(32'h1044, h1, d);
        probe(32'h1048, h2, d);
        n_checks++;
        if ({h0, h1, h2} !== 3'b000) begin $display("FAIL flush_cleared: got %b expected 000", {h0, h1, h2}); n_fail++; end
        probe(32'h3008, h, d);
        n_checks++;
        if (h !== 1'b1 || d !== 32'h3333_3333 || bus.wr_miss_cnt !== 16'd6) begin
            $display("FAIL flush_pending: got %b %h miss %0d expected 1 33333333 6", h, d, bus.wr_miss_cnt); n_fail++;
        end
    endtask

    task automatic test_reset_mid_write();
        logic req_seen, ack_seen, h; logic [31:0] d;
        ack_seen = 1'b0;
        bus.stb2dcache_addr = 32'h100C; bus.stb2dcache_wdata = 32'h4444_4444;
        bus.stb2dcache_sel_byte = 4'b1111; bus.stb2dcache_w_en = 1'b1; bus.stb2dcache_req = 1'b1;
        bus.mem2dcache_ack = 1'b0;
        repeat (2) @(negedge clk);
        req_seen = bus.dcache2mem_req;
        rst = 1'b1; bus.stb2dcache_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_seen !== 1'b1 || bus.dcache2mem_req !== 1'b0) begin
            $display("FAIL rst_mid_req: got before %b after %b expected 1 0", req_seen, bus.dcache2mem_req); n_fail++;
        end
        probe(32'h3008, h, d);
        n_checks++;
        if (h !== 1'b0 || bus.wr_miss_cnt !== 16'd0) begin
            $display("FAIL rst_mid_state: got rhit %b miss %0d expected 0 0", h, bus.wr_miss_cnt); n_fail++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.dcache2stb_ack || bus.dcache2mem_req) ack_seen = 1'b1;
        end
        n_checks++;
        if (ack_seen !== 1'b0) begin $display("FAIL rst_mid_no_ack: got activity %b expected 0", ack_seen); n_fail++; end
    endtask

    initial begin
        bus.stb2dcache_addr = '0; bus.stb2dcache_wdata = '0; bus.stb2dcache_sel_byte = '0;
        bus.stb2dcache_w_en = 1'b0; bus.stb2dcache_req = 1'b0; bus.dmem_sel_i = 1'b1;
        bus.mem2dcache_ack = 1'b0; bus.dcache_flush = 1'b0; bus.lsummu2dcache_raddr = '0;
        test_reset();
        test_miss_allocate();
        test_hit_merge();
        test_partial_miss_alias();
        test_backpressure();
        test_read_only();
        test_back_to_back();
        test_flush_race();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_stb_writer.md
# dcache_stb_writer

Write-side controller of the data cache. It sits directly downstream of the store buffer and drains its entries one at a time. Each drained store is merged into a small direct-mapped, write-through cache and forwarded to data memory. The store buffer gets its acknowledge only after memory has accepted the write. A combinational read-probe port exposes the cache contents to the LSU and the bench, and a flush input invalidates every line.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, word width; one word per line.
- `BYTE_SEL_WIDTH`, 4, byte-enable width (DATA_WIDTH/8).
- `NUM_LINES`, 16, cache lines; power of two ≥ 2. IDX_W = $clog2(NUM_LINES), TAG_W = ADDR_WIDTH-IDX_W-2.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `stb2dcache_addr`  in  ADDR_WIDTH  store address; bits [1:0] ignored.
- `stb2dcache_wdata`  in  DATA_WIDTH  store data.
- `stb2dcache_sel_byte`  in  BYTE_SEL_WIDTH  byte enables.
- `stb2dcache_w_en`  in  1  write enable.
- `stb2dcache_req`  in  1  request valid.
- `dmem_sel_i`  in  1  data-memory select; a request is accepted only when this is 1.
- `dcache2stb_ack`  out  1  one-cycle completion pulse to the store buffer.
- `dcache2mem_addr`  out  ADDR_WIDTH  memory write address, word-aligned.
- `dcache2mem_wdata`  out  DATA_WIDTH  memory write data.
- `dcache2mem_sel_byte`  out  BYTE_SEL_WIDTH  memory byte enables.
- `dcache2mem_req`  out  1  memory write request.
- `mem2dcache_ack`  in  1  memory accepted the write.
- `dcache_flush`  in  1  level flush request.
- `dcache_flush_busy`  out  1  high while in FLUSH.
- `lsummu2dcache_raddr`  in  ADDR_WIDTH  read-probe address.
- `dcache2lsummu_rdata`  out  DATA_WIDTH  probe data, combinational.
- `dcache2lsummu_rhit`  out  1  probe hit (valid and tag match), combinational.
- `wr_hit_cnt`  out  16  saturating count of write hits.
- `wr_miss_cnt`  out  16  saturating count of write misses.

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[ADDR_WIDTH-1:IDX_W+2].
- Storage per line: a valid bit, a tag and one data word. Only the valid bits and the counters are reset.
- States: IDLE, LOOKUP, MEM_WR, ACK, FLUSH.
- **IDLE**
  - If `dcache_flush`=1, go to FLUSH. Flush has priority over a simultaneous request.
  - Otherwise, if `stb2dcache_req`=1 and `dmem_sel_i`=1, capture addr, wdata, sel_byte and w_en into holding registers and go to LOOKUP.
  - In all other cases, stay in IDLE.
- **LOOKUP**, when the captured w_en=0: no cache update, no memory access, no counter change; go to ACK.
- **LOOKUP**, on a hit (valid and tag match):
  - Each byte i of the line's data is replaced by wdata byte i where sel_byte[i]=1.
  - `wr_hit_cnt` +1, saturating at 16'hFFFF.
  - Go to MEM_WR.
- **LOOKUP**, on a miss:
  - `wr_miss_cnt` +1, saturating.
  - If sel_byte is all ones, allocate: set valid, write the tag, write the data.
  - If sel_byte is partial, leave the cache unchanged.
  - Go to MEM_WR.
- **MEM_WR**
  - `dcache2mem_req`=1, with addr (low two bits forced to 0), wdata and sel_byte driven from the holding registers.
  - When `mem2dcache_ack` is sampled 1, go to ACK.
- **ACK**: `dcache2stb_ack`=1 for exactly this one cycle, then go to IDLE.
- **FLUSH**
  - A NUM_LINES-wide counter clears one valid bit per cycle, index 0 first.
  - Leave after clearing index NUM_LINES-1: exactly NUM_LINES cycles, then IDLE. The counter wraps to 0.
  - `dcache_flush` is ignored while in FLUSH.
- Probe port: reads the arrays directly with no state dependence. A write done in LOOKUP is visible on the probe from the next cycle.

## Timing
- Reset values (all outputs 0 on the edge where rst=1):
  - `dcache2stb_ack`, `dcache2mem_req`, `dcache_flush_busy`, `dcache2mem_addr`, `dcache2mem_wdata`, `dcache2mem_sel_byte` are 0.
  - Both counters are 0 and all valid bits are 0.
  - `dcache2lsummu_rhit` is therefore 0.
- Reset mid-operation: the state returns to IDLE and `dcache2mem_req` is 0 from the next cycle. No ack is issued for the aborted store. Any cache update already written in LOOKUP is discarded because the valid bits are cleared.
- Write latency: request sampled at edge E0, LOOKUP during E0–E1, `dcache2mem_req` high from E1. With zero-wait memory (ack in the first req cycle), `dcache2stb_ack` is high in cycle E2–E3, giving a minimum of 3 cycles from request to ack. Each memory wait cycle adds one cycle.
- Latency when w_en=0: ack in cycle E1–E2.
- `dcache2mem_req` and its address/data/byte-enable outputs stay stable until the ack is sampled. Memory sees exactly one request per store.
- The store buffer must drop `stb2dcache_req`, or present its next entry, in the cycle after ack. The request is resampled only in IDLE, which is the cycle after ACK. Back-to-back stores therefore complete at one per 4 cycles with zero-wait memory.
- A flush raised while a store is in flight is serviced on return to IDLE, as long as it is still held high.

## Test plan
- **Reset:** hold rst for 2 cycles -> all outputs 0; a probe of 0x1000 gives rhit=0.
- **Full-word miss allocate:** write 0x1000/AAAA_BBBB/1111 with zero-wait memory -> mem req 0x1000 AAAA_BBBB 1111; ack 3 cycles after the request; miss_cnt=1; probe 0x1000 gives rhit=1, rdata=AAAA_BBBB.
- **Partial hit merge:** after the previous scenario, write 0x1000/1234_5678/0101 -> probe rdata AA34_BB78; hit_cnt=1; memory sees sel 0101.
- **Partial miss and index aliasing:** write 0x2004/FFFF_DDDD/0011 -> no allocate, probe rhit=0, miss_cnt+1. Then write 0x1040/CCCC_DDDD/1111 (same index as 0x1000) -> probe 0x1040 hits and probe 0x1000 misses.
- **Memory backpressure:** hold mem2dcache_ack low for 5 cycles -> req and its address/data/byte-enable outputs stay stable; ack to the store buffer comes 8 cycles after the request; no duplicate memory request.
- **Flush races:** assert flush together with req in IDLE -> flush_busy is high for 16 cycles; afterwards every previously valid address misses on the probe; the pending store is then accepted normally. Also assert rst during MEM_WR -> no ack, req drops.
